load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of `datapath`.
- Consumes the datapath's ALU result (effective address), store data and access size.
- Runs the word-wide data-memory bus through a req/ack handshake, and returns the aligned, sign/zero-extended load value on `o_readData`, which feeds the datapath's `i_readData`.
- Asserts `o_stall` to freeze PC and register write-back while a transaction is outstanding.

Parameters:
- ACK_TIMEOUT, 16, ack-wait limit per bus beat in cycles; 0 disables the timeout.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous, active-high reset
- i_memRead  input  1  load request from control
- i_memWrite  input  1  store request from control
- i_memSize  input  2  00 byte, 01 half, 10 word, 11 treated as word
- i_loadUnsigned  input  1  1 = zero-extend load, 0 = sign-extend
- i_addr  input  32  effective byte address (datapath ALU out)
- i_writeData  input  32  store data, LSB-aligned
- o_readData  output  32  extended load result
- o_stall  output  1  hold PC/pipeline this cycle
- o_misaligned  output  1  one-cycle pulse: misaligned access rejected
- o_busFault  output  1  one-cycle pulse: ack timeout
- o_memReq  output  1  bus request
- o_memWe  output  1  1 = write beat
- o_memAddr  output  32  word-aligned address, bits [1:0] always 00
- o_memByteEn  output  4  byte lane enables, lane k = bits [8k+7:8k]
- o_memWdata  output  32  lane-positioned write data
- i_memAck  input  1  beat accepted; read data valid in the same cycle
- i_memRdata  input  32  read data

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE.
  - All registered outputs = 0 (`o_readData`, `o_memReq`, `o_memWe`, `o_memAddr`, `o_memByteEn`, `o_memWdata`, `o_misaligned`, `o_busFault`).
  - Reset mid-transaction abandons it; `o_memReq` is low from the next cycle and no partial write is retried.
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- IDLE:
  - If `i_memRead|i_memWrite`: latch addr, size, data, the unsigned flag and we, then go to BEAT0.
  - Both request inputs high: treated as a store.
  - `o_stall` = `i_memRead|i_memWrite` (combinational, same cycle).
- BEAT0 / BEAT1:
  - `o_stall` = 1 and `o_memReq` = 1.
  - `o_memAddr`, `o_memByteEn`, `o_memWdata` are held stable until `i_memAck`.
- Lane math (off = addr[1:0]):
  - 8-bit mask = (0001, 0011, 1111 by size) << off.
  - 64-bit data = writeData << 8*off.
  - BEAT0 uses the low halves at {addr[31:2],00}.
  - BEAT1 uses the high halves at that address + 4, with 32-bit wrap (FFFFFFFC+4 = 00000000).
- Transitions:
  - BEAT0 ack: go to BEAT1 if the high mask is nonzero, else DONE.
  - BEAT1 ack: go to DONE.
- Load assembly:
  - Read beats fill a 64-bit buffer {beat1, beat0}.
  - The result is buffer >> 8*off, truncated to the size, then sign- or zero-extended.
  - A word load ignores `i_loadUnsigned`.
- DONE:
  - `o_stall` = 0 for exactly one cycle; the datapath advances at this edge. Then go to IDLE.
  - `o_readData` is registered on entry to DONE for loads and holds until the next load completes.
  - Stores leave `o_readData` unchanged.
- Back-to-back accesses: the next request is sampled in the IDLE cycle after DONE, so minimum latency is 3 cycles per single-beat access with immediate ack.
- Timeout (ACK_TIMEOUT > 0):
  - A counter resets at each beat start and increments each cycle without ack.
  - At ACK_TIMEOUT: drop `o_memReq`, go to DONE, pulse `o_busFault`; a load returns 0.
- `i_memAck` outside BEAT0/BEAT1 is ignored.

Optional Feature:
- Macro: MISALIGNED_SPLIT_EN.
- Defined:
  - Accesses that cross a word boundary (half at off=3, word at off≠0) run as two beats.
  - `o_misaligned` is tied to 0.
- Undefined:
  - Any access with size-misaligned off (half with off[0]=1, word with off≠0) issues no bus beat and goes IDLE→DONE.
  - `o_misaligned` pulses in DONE; a load returns 0; a store writes nothing.
  - BEAT1 is unreachable.

Test Plan:
- Word load, addr 0x100, `i_memRdata` 0xDEADBEEF, ack in the first cycle → `o_memAddr` 0x100, byteEn 1111, `o_readData` 0xDEADBEEF, stall high for 2 cycles.
- Byte load, signed, addr 0x103, rdata 0x80FFFFFF → byteEn 1000, `o_readData` 0xFFFFFF80; repeat with `i_loadUnsigned`=1 → 0x00000080.
- Half store, addr 0x102, writeData 0x1234ABCD → byteEn 1100, `o_memWdata` 0xABCD0000, `o_memWe`=1.
- Word store at 0x101 with MISALIGNED_SPLIT_EN, writeData 0x11223344:
  - Beat0: addr 0x100, byteEn 1110, wdata 0x22334400.
  - Beat1: addr 0x104, byteEn 0001, wdata 0x00000011.
  - Without the macro: no `o_memReq`, `o_misaligned` pulses once.
- Ack withheld with ACK_TIMEOUT=16 → `o_memReq` drops after 16 cycles, `o_busFault` pulses once, `o_stall` falls, `o_readData` = 0.
- `i_reset` asserted in BEAT0 of a store → next cycle `o_memReq`=0, `o_stall` reflects only the IDLE request inputs, all outputs are 0.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-access stage: runs a word-wide req/ack data bus and returns aligned, extended load data.
// Optional macro MISALIGNED_SPLIT_EN: word-crossing accesses run as two beats instead of being rejected.
module load_store_unit #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [1:0]  i_memSize,
    input  logic        i_loadUnsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_writeData,
    output logic [31:0] o_readData,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_busFault,
    output logic        o_memReq,
    output logic        o_memWe,
    output logic [31:0] o_memAddr,
    output logic [3:0]  o_memByteEn,
    output logic [31:0] o_memWdata,
    input  logic        i_memAck,
    input  logic [31:0] i_memRdata
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    state_t        state, state_nxt;
    logic [31:0]   addr_q, wdata_q, rbuf0;
    logic [1:0]    size_q;
    logic          uns_q, we_q;
    logic [CW-1:0] cnt;

    logic          req_any, req_misal, tmo_hit, stall;
    logic [1:0]    sel_off, sel_size;
    logic [31:0]   sel_data;
    logic [7:0]    lane_base, lane_mask;
    logic [63:0]   lane_data, load_buf;
    logic [31:0]   load_sh, load_val;

    assign req_any = i_memRead | i_memWrite;

`ifdef MISALIGNED_SPLIT_EN
    assign req_misal = 1'b0;
`else
    assign req_misal = ((i_memSize == 2'b01) && i_addr[0]) ||
                       (i_memSize[1] && (i_addr[1:0] != 2'b00));
`endif

    assign tmo_hit = (ACK_TIMEOUT != 0) && (cnt == CW'(ACK_TIMEOUT - 1));

    // Lane math is shared: live inputs set up BEAT0, latched fields set up BEAT1.
    assign sel_off  = (state == IDLE) ? i_addr[1:0] : addr_q[1:0];
    assign sel_size = (state == IDLE) ? i_memSize   : size_q;
    assign sel_data = (state == IDLE) ? i_writeData : wdata_q;

    always_comb begin
        case (sel_size)
            2'b00:   lane_base = 8'b0000_0001;
            2'b01:   lane_base = 8'b0000_0011;
            default: lane_base = 8'b0000_1111;
        endcase
    end

    assign lane_mask = lane_base << sel_off;
    assign lane_data = {32'h0, sel_data} << {sel_off, 3'b000};

    always_comb begin
        load_buf = (state == BEAT1) ? {i_memRdata, rbuf0} : {32'h0, i_memRdata};
        load_sh  = 32'(load_buf >> {addr_q[1:0], 3'b000});
        case (size_q)
            2'b00:   load_val = uns_q ? {24'h0, load_sh[7:0]}  : {{24{load_sh[7]}}, load_sh[7:0]};
            2'b01:   load_val = uns_q ? {16'h0, load_sh[15:0]} : {{16{load_sh[15]}}, load_sh[15:0]};
            default: load_val = load_sh;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = req_any;
                if (req_any)
                    state_nxt = req_misal ? DONE : BEAT0;
            end
            BEAT0: begin
                stall = 1'b1;
                if (i_memAck)
                    state_nxt = (lane_mask[7:4] != 4'b0000) ? BEAT1 : DONE;
                else if (tmo_hit)
                    state_nxt = DONE;
            end
            BEAT1: begin
                stall = 1'b1;
                if (i_memAck || tmo_hit)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_stall = stall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rbuf0        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            we_q         <= 1'b0;
            cnt          <= '0;
            o_readData   <= '0;
            o_memReq     <= 1'b0;
            o_memWe      <= 1'b0;
            o_memAddr    <= '0;
            o_memByteEn  <= '0;
            o_memWdata   <= '0;
            o_misaligned <= 1'b0;
            o_busFault   <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_misaligned <= 1'b0;
            o_busFault   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        addr_q  <= i_addr;
                        size_q  <= i_memSize;
                        wdata_q <= i_writeData;
                        uns_q   <= i_loadUnsigned;
                        we_q    <= i_memWrite;
                        cnt     <= '0;
                        if (req_misal) begin
                            o_misaligned <= 1'b1;
                            if (!i_memWrite)
                                o_readData <= '0;
                        end else begin
                            o_memReq    <= 1'b1;
                            o_memWe     <= i_memWrite;
                            o_memAddr   <= {i_addr[31:2], 2'b00};
                            o_memByteEn <= lane_mask[3:0];
                            o_memWdata  <= lane_data[31:0];
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (i_memAck) begin
                        cnt <= '0;
                        if (state_nxt == BEAT1) begin
                            rbuf0       <= i_memRdata;
                            o_memAddr   <= {addr_q[31:2] + 30'd1, 2'b00};
                            o_memByteEn <= lane_mask[7:4];
                            o_memWdata  <= lane_data[63:32];
                        end else begin
                            o_memReq    <= 1'b0;
                            o_memWe     <= 1'b0;
                            o_memByteEn <= '0;
                            if (!we_q)
                                o_readData <= load_val;
                        end
                    end else if (tmo_hit) begin
                        // Abandon the beat; a faulted load reads as zero.
                        o_memReq    <= 1'b0;
                        o_memWe     <= 1'b0;
                        o_memByteEn <= '0;
                        o_busFault  <= 1'b1;
                        if (!we_q)
                            o_readData <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected beats/completions, a monitor pops and compares.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, load_uns;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic [31:0] read_data;
    logic        stall, misaligned, bus_fault;
    logic        req, we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  byte_en;
    logic        ack;

    int total = 0;
    int bad   = 0;

    logic        ack_en = 1'b1;
    int          ack_delay = 0;
    int          req_age = 0;
    logic        beat_idx = 1'b0;
    logic [31:0] rd_lo = '0, rd_hi = '0;
    logic        mon_en = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
    } beat_t;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        flt;
        int          stall_len;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    load_store_unit #(.ACK_TIMEOUT(16)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_memRead      (mem_read),
        .i_memWrite     (mem_write),
        .i_memSize      (mem_size),
        .i_loadUnsigned (load_uns),
        .i_addr         (addr),
        .i_writeData    (wdata),
        .o_readData     (read_data),
        .o_stall        (stall),
        .o_misaligned   (misaligned),
        .o_busFault     (bus_fault),
        .o_memReq       (req),
        .o_memWe        (we),
        .o_memAddr      (bus_addr),
        .o_memByteEn    (byte_en),
        .o_memWdata     (bus_wdata),
        .i_memAck       (ack),
        .i_memRdata     (bus_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: acks after ack_delay waiting cycles, beat 1 returns rd_hi.
    assign ack       = req && ack_en && (req_age >= ack_delay);
    assign bus_rdata = beat_idx ? rd_hi : rd_lo;

    always @(posedge clk) begin
        req_age  <= (req && !ack) ? req_age + 1 : 0;
        beat_idx <= !req ? 1'b0 : (ack ? 1'b1 : beat_idx);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic w, input logic [31:0] d);
        beat_t b;
        b.addr = a; b.be = be; b.we = w; b.wd = d;
        beat_q.push_back(b);
    endtask

    task automatic push_done(input logic [31:0] rd, input logic mis, input logic flt, input int sl);
        done_t d;
        d.rd = rd; d.mis = mis; d.flt = flt; d.stall_len = sl;
        done_q.push_back(d);
    endtask

    // Issue one access from IDLE and return in the IDLE cycle after DONE.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] lo, input logic [31:0] hi,
                             input int dly, output int reqc);
        int n;
        rd_lo = lo; rd_hi = hi; ack_delay = dly;
        mem_read = rd; mem_write = wr; mem_size = sz; load_uns = uns; addr = a; wdata = wd;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        reqc = int'(req);
        n = 0;
        while (stall && n < 100) begin
            @(posedge clk); #1;
            reqc += int'(req);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL access bound: stall still high at addr %h", a);
        end
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        int    run;
        beat_t b;
        done_t d;
        run = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                run = 0;
            end else begin
                if (req && ack) begin
                    if (beat_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected beat: got addr %h want none", bus_addr);
                    end else begin
                        b = beat_q.pop_front();
                        check("beat addr", bus_addr, b.addr);
                        check("beat byteEn", {28'h0, byte_en}, {28'h0, b.be});
                        check("beat we", {31'h0, we}, {31'h0, b.we});
                        check("beat wdata", bus_wdata, b.wd);
                    end
                end
                if (stall) begin
                    run++;
                end else if (run != 0) begin
                    if (done_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected completion: got readData %h want none", read_data);
                    end else begin
                        d = done_q.pop_front();
                        check("readData", read_data, d.rd);
                        check("misaligned", {31'h0, misaligned}, {31'h0, d.mis});
                        check("busFault", {31'h0, bus_fault}, {31'h0, d.flt});
                        check("stall cycles", 32'(run), 32'(d.stall_len));
                    end
                    run = 0;
                end else if (misaligned || bus_fault) begin
                    total++; bad++;
                    $display("FAIL stray pulse: got mis=%0b flt=%0b want 0", misaligned, bus_fault);
                end
            end
        end
    end

    initial begin : stimulus
        int rc;
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; load_uns = 1'b0;
        addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset readData", read_data, 32'h0);
        check("reset memReq", {31'h0, req}, 32'h0);
        check("reset memAddr", bus_addr, 32'h0);
        check("reset stall", {31'h0, stall}, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // word load, immediate ack
        push_beat(32'h100, 4'b1111, 1'b0, 32'h0);
        push_done(32'hDEADBEEF, 1'b0, 1'b0, 2);
        do_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, rc);

        // byte load at lane 3, signed then unsigned
        push_beat(32'h100, 4'b1000, 1'b0, 32'h0);
        push_done(32'hFFFFFF80, 1'b0, 1'b0, 2);
        do_access(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FFFFFF, 32'h0, 0, rc);
        push_beat(32'h100, 4'b1000, 1'b0, 32'h0);
        push_done(32'h00000080, 1'b0, 1'b0, 2);
        do_access(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FFFFFF, 32'h0, 0, rc);

        // half store, readData untouched
        push_beat(32'h100, 4'b1100, 1'b1, 32'hABCD0000);
        push_done(32'h00000080, 1'b0, 1'b0, 2);
        do_access(0, 1, 2'b01, 0, 32'h102, 32'h1234ABCD, 32'h0, 32'h0, 0, rc);

`ifdef MISALIGNED_SPLIT_EN
        push_beat(32'h100, 4'b1110, 1'b1, 32'h22334400);
        push_beat(32'h104, 4'b0001, 1'b1, 32'h00000011);
        push_done(32'h00000080, 1'b0, 1'b0, 3);
        do_access(0, 1, 2'b10, 0, 32'h101, 32'h11223344, 32'h0, 32'h0, 0, rc);
        // half load crossing the top of memory wraps to 0
        push_beat(32'hFFFFFFFC, 4'b1000, 1'b0, 32'h0);
        push_beat(32'h00000000, 4'b0001, 1'b0, 32'h0);
        push_done(32'h00003412, 1'b0, 1'b0, 3);
        do_access(1, 0, 2'b01, 0, 32'hFFFFFFFF, 32'h0, 32'h12000000, 32'h00000034, 0, rc);
`else
        push_done(32'h00000080, 1'b1, 1'b0, 1);
        do_access(0, 1, 2'b10, 0, 32'h101, 32'h11223344, 32'h0, 32'h0, 0, rc);
        check("misaligned store no req", 32'(rc), 32'd0);
        push_done(32'h00000000, 1'b1, 1'b0, 1);
        do_access(1, 0, 2'b01, 0, 32'hFFFFFFFF, 32'h0, 32'h12000000, 32'h00000034, 0, rc);
`endif

        // signed half load with 3-cycle ack delay
        push_beat(32'h100, 4'b1100, 1'b0, 32'h0);
        push_done(32'hFFFF8001, 1'b0, 1'b0, 5);
        do_access(1, 0, 2'b01, 0, 32'h102, 32'h0, 32'h80011234, 32'h0, 3, rc);

        // both request lines high is a store
        push_beat(32'h300, 4'b1111, 1'b1, 32'hCAFEF00D);
        push_done(32'hFFFF8001, 1'b0, 1'b0, 2);
        do_access(1, 1, 2'b10, 0, 32'h300, 32'hCAFEF00D, 32'h0, 32'h0, 0, rc);

        // size 11 is a word and ignores the unsigned flag
        push_beat(32'h104, 4'b1111, 1'b0, 32'h0);
        push_done(32'h81020304, 1'b0, 1'b0, 2);
        do_access(1, 0, 2'b11, 1, 32'h104, 32'h0, 32'h81020304, 32'h0, 0, rc);

        push_beat(32'h100, 4'b0001, 1'b0, 32'h0);
        push_done(32'h0000007F, 1'b0, 1'b0, 2);
        do_access(1, 0, 2'b00, 0, 32'h100, 32'h0, 32'h0000007F, 32'h0, 0, rc);

        // ack withheld: timeout after 16 request cycles
        ack_en = 1'b0;
        push_done(32'h00000000, 1'b0, 1'b1, 17);
        do_access(1, 0, 2'b10, 0, 32'h200, 32'h0, 32'h0, 32'h0, 0, rc);
        check("timeout req cycles", 32'(rc), 32'd16);

        // reset during BEAT0 of a store
        mon_en = 1'b0;
        push_beat(32'h0, 4'b0, 1'b0, 32'h0);
        void'(beat_q.pop_back());
        mem_write = 1'b1; mem_size = 2'b10; addr = 32'h400; wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        mem_write = 1'b0;
        check("pre-reset memReq", {31'h0, req}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst memReq", {31'h0, req}, 32'h0);
        check("rst memWe", {31'h0, we}, 32'h0);
        check("rst memAddr", bus_addr, 32'h0);
        check("rst byteEn", {28'h0, byte_en}, 32'h0);
        check("rst memWdata", bus_wdata, 32'h0);
        check("rst readData", read_data, 32'h0);
        check("rst stall idle", {31'h0, stall}, 32'h0);
        mem_read = 1'b1; #1;
        check("rst stall follows req", {31'h0, stall}, 32'h1);
        mem_read = 1'b0;
        rst = 1'b0;
        ack_en = 1'b1;
        @(posedge clk); #1;
        check("post-reset no retry", {31'h0, req}, 32'h0);
        mon_en = 1'b1;

        push_beat(32'h104, 4'b1111, 1'b0, 32'h0);
        push_done(32'h0BADF00D, 1'b0, 1'b0, 2);
        do_access(1, 0, 2'b10, 0, 32'h104, 32'h0, 32'h0BADF00D, 32'h0, 0, rc);

        repeat (3) @(posedge clk);
        #1;
        check("beats left", 32'(beat_q.size()), 32'd0);
        check("completions left", 32'(done_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
